cursor_ctrl: RTL and testbench
==============================

Name: cursor_ctrl

Overview:
Converts raw push-button inputs into the 3-bit cursor coordinates pos_x/pos_y consumed by the 8x8 board square generator (pos_x = column 0..7, pos_y = row 0..7).
Provides debouncing, hold-to-repeat and frame-synchronous cursor updates, so the highlighted square never changes mid-frame.
Emits a one-cycle select strobe carrying the confirmed square to the game logic.
Sits between the board I/O pins and the VGA drawing path.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronized samples required before a button's debounced level changes
REPEAT_DELAY, 24'd12500000, cycles a direction must stay held after its first step before auto-repeat starts
REPEAT_PERIOD, 24'd5000000, cycles between auto-repeat steps
WRAP, 1, 1 = coordinates wrap 7<->0; 0 = coordinates saturate at 0 and 7

Ports:
clk  in  1  system clock (pixel-domain clock)
rst_n  in  1  asynchronous active-low reset
btn_up  in  1  raw button, active-high, asynchronous
btn_down  in  1  raw button, active-high, asynchronous
btn_left  in  1  raw button, active-high, asynchronous
btn_right  in  1  raw button, active-high, asynchronous
btn_sel  in  1  raw select button, active-high, asynchronous
frame_start  in  1  one-cycle pulse at start of vertical blanking
lock  in  1  1 = ignore movement and select (e.g. opponent's turn)
pos_x  out  3  displayed cursor column
pos_y  out  3  displayed cursor row
sel_valid  out  1  one-cycle select strobe
sel_x  out  3  column captured with sel_valid
sel_y  out  3  row captured with sel_valid

Behaviour:
- Reset (rst_n low, async): pos_x=0, pos_y=0, sel_valid=0, sel_x=0, sel_y=0; sync/debounce state cleared to 0; pending steps cleared; FSM=IDLE. Release is synchronous in effect; the first sample is taken on the first clk edge after release.
- Each button: 2-FF synchronizer, then debounce counter.
  - The counter resets whenever the synced sample equals the debounced level.
  - The debounced level toggles when the counter reaches DEBOUNCE_CYCLES-1.
  - Latency from a stable raw edge to the debounced edge is DEBOUNCE_CYCLES+2 cycles.
- Direction vector dir = {up,down,left,right} (debounced).
  - Opposite pairs pressed together cancel on that axis.
  - The x and y axes are independent, so diagonal moves are allowed.
- Repeat FSM, over "any effective direction active" (act):
  - IDLE: act rises -> issue step, load counter REPEAT_DELAY, go to DELAY.
  - DELAY: act falls -> IDLE. Counter reaches 0 -> issue step, load REPEAT_PERIOD, go to REPEAT.
  - REPEAT: act falls -> IDLE. Counter reaches 0 -> issue step, reload REPEAT_PERIOD.
  - A change of dir while act stays high restarts the sequence: issue step immediately, go to DELAY.
- Step issue: records pending_dx, pending_dy in {-1,0,+1}, using the effective dir at that cycle.
  - A newer step overwrites an unapplied pending step; steps never accumulate beyond 1 per axis.
- Frame-synchronous apply: on a frame_start cycle, pending steps are added to pos_x/pos_y (visible the next cycle) and pending is cleared.
  - A step issued in the same cycle as frame_start is applied at the next frame_start.
- Arithmetic: 3-bit. With WRAP=1, 7+1=0 and 0-1=7. With WRAP=0, values saturate at 0 and 7.
- Select: rising edge of debounced btn_sel -> sel_valid=1 for exactly one cycle, with sel_x/sel_y = pos_x/pos_y as registered that cycle (the displayed square, not the pending one).
  - sel_x/sel_y hold their value until the next select.
- lock=1:
  - No steps are issued and sel edges are discarded.
  - The FSM returns to IDLE; already-pending steps are cleared.
  - Debouncers keep running, so a held button does not step when lock falls; the next step needs a new press.
  - pos holds.
- Reset mid-hold or mid-debounce: everything returns to reset values; a button still held at release is treated as a new press once debounced.

Decomposition:
- Package cursor_pkg holds:
  - constants GRID_N=8 and COORD_W=3;
  - typedef coord_t (logic [2:0]);
  - enum rep_state_t {IDLE, DELAY, REPEAT};
  - typedef step_t (logic signed [1:0]).
- Sub-module btn_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES, outputs level and rise pulse), instantiated 5 times.
- FSM, pending registers and coordinate math stay in cursor_ctrl.

Test Plan:
- Parameters for simulation: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, frame_start every 10 cycles.
- Reset: assert rst_n=0 mid-run with btn_right held -> all outputs 0 immediately, without a clk edge. Release -> pos stays (0,0) until the debounced press is followed by a frame_start, then pos_x=1.
- Glitch rejection: btn_up pulses high for 3 cycles -> no step and pos_y unchanged. A clean press of 10 cycles -> exactly one step, pos_y=7 with WRAP=1, or 0 with WRAP=0.
- Hold-repeat: hold btn_right for 60 cycles from (0,0) -> steps at the press, +20 and +28 (+8 apart) and so on; pos_x advances only on frame_start edges. Any step overwritten before a frame_start is lost by design.
- Diagonal and cancel: btn_down+btn_right -> (1,1). Then btn_left+btn_right+btn_down -> x unchanged, y=2.
- Select: move to (3,5), press btn_sel -> single-cycle sel_valid with sel_x=3, sel_y=5. Holding btn_sel 100 cycles -> no further strobes.
- Lock: lock=1 while pressing btn_down and btn_sel -> no pos change and no sel_valid. Lock drops while the button is still held -> no step until release and re-press.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared types and coordinate arithmetic for the board cursor controller.
package cursor_pkg;

  localparam int GRID_N  = 8;
  localparam int COORD_W = 3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic signed [1:0] step_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  localparam step_t STEP_NONE = 2'sb00;
  localparam step_t STEP_POS  = 2'sb01;
  localparam step_t STEP_NEG  = 2'sb11;

  // Moves one coordinate by a single step, either wrapping or clamping at the board edge.
  function automatic coord_t coord_step(input coord_t c, input step_t s, input bit wrap);
    coord_t r;
    r = c;
    if (s == STEP_POS) begin
      if (c != coord_t'(GRID_N - 1)) r = c + coord_t'(1);
      else if (wrap) r = '0;
    end else if (s == STEP_NEG) begin
      if (c != '0) r = c - coord_t'(1);
      else if (wrap) r = coord_t'(GRID_N - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push button.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic sync_a;
  logic sync_b;
  logic [15:0] cnt;

  // The level only flips after the synced sample has disagreed with it for a full count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      rise   <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Button-driven 8x8 board cursor with hold-to-repeat, frame-synchronous moves and select strobe.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd12500000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000,
  parameter bit          WRAP            = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   btn_up,
  input  logic   btn_down,
  input  logic   btn_left,
  input  logic   btn_right,
  input  logic   btn_sel,
  input  logic   frame_start,
  input  logic   lock,
  output coord_t pos_x,
  output coord_t pos_y,
  output logic   sel_valid,
  output coord_t sel_x,
  output coord_t sel_y
);

  logic [3:0] dir_level;
  logic [3:0] dir_rise;
  logic       sel_level;
  logic       sel_rise;
  logic       unused_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(dir_level[3]), .rise(dir_rise[3]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(dir_level[2]), .rise(dir_rise[2]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst_n(rst_n), .raw(btn_left), .level(dir_level[1]), .rise(dir_rise[1]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst_n(rst_n), .raw(btn_right), .level(dir_level[0]), .rise(dir_rise[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .rst_n(rst_n), .raw(btn_sel), .level(sel_level), .rise(sel_rise));

  assign unused_ok = ^{dir_rise, sel_level};

  step_t      dx, dy, dx_q, dy_q, pend_dx, pend_dy;
  logic       act, act_q, changed, expired, step_go;
  rep_state_t state;
  logic [23:0] rep_cnt;

  // Opposite buttons cancel per axis; up moves toward row 0.
  always_comb begin
    dx = STEP_NONE;
    dy = STEP_NONE;
    if (dir_level[0] && !dir_level[1]) dx = STEP_POS;
    else if (dir_level[1] && !dir_level[0]) dx = STEP_NEG;
    if (dir_level[2] && !dir_level[3]) dy = STEP_POS;
    else if (dir_level[3] && !dir_level[2]) dy = STEP_NEG;
  end

  assign act     = (dx != STEP_NONE) || (dy != STEP_NONE);
  assign changed = act && (!act_q || dx != dx_q || dy != dy_q);
  assign expired = (state != IDLE) && (rep_cnt <= 24'd1);
  assign step_go = !lock && act && (changed || expired);

  // The previous effective direction is tracked even while locked, so a button held
  // through the lock does not look like a fresh press when the lock drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      act_q     <= 1'b0;
      dx_q      <= STEP_NONE;
      dy_q      <= STEP_NONE;
      pend_dx   <= STEP_NONE;
      pend_dy   <= STEP_NONE;
      pos_x     <= '0;
      pos_y     <= '0;
      sel_valid <= 1'b0;
      sel_x     <= '0;
      sel_y     <= '0;
    end else begin
      act_q     <= act;
      dx_q      <= dx;
      dy_q      <= dy;
      sel_valid <= 1'b0;

      if (lock || !act) begin
        state <= IDLE;
      end else if (changed) begin
        state   <= DELAY;
        rep_cnt <= REPEAT_DELAY;
      end else if (state != IDLE) begin
        if (expired) begin
          state   <= REPEAT;
          rep_cnt <= REPEAT_PERIOD;
        end else begin
          rep_cnt <= rep_cnt - 24'd1;
        end
      end

      if (frame_start && !lock) begin
        pos_x <= coord_step(pos_x, pend_dx, WRAP);
        pos_y <= coord_step(pos_y, pend_dy, WRAP);
      end

      // A step issued on a frame_start cycle survives to the following frame.
      if (lock) begin
        pend_dx <= STEP_NONE;
        pend_dy <= STEP_NONE;
      end else if (step_go) begin
        pend_dx <= dx;
        pend_dy <= dy;
      end else if (frame_start) begin
        pend_dx <= STEP_NONE;
        pend_dy <= STEP_NONE;
      end

      if (sel_rise && !lock) begin
        sel_valid <= 1'b1;
        sel_x     <= pos_x;
        sel_y     <= pos_y;
      end
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl; positions are encoded as x*10+y in the queues.
module tb_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_sel = 1'b0;
  logic       lock = 1'b0;
  logic       frame_start;
  logic [2:0] pos_x, pos_y, sel_x, sel_y;
  logic       sel_valid;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int pos_q[$];
  int sel_q[$];

  cursor_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY(24'd20),
    .REPEAT_PERIOD(24'd8),
    .WRAP(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .frame_start(frame_start), .lock(lock),
    .pos_x(pos_x), .pos_y(pos_y),
    .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y)
  );

  always #5 clk = ~clk;

  // Frame pulse is sampled by the DUT on edges whose cycle number is a multiple of 10.
  always @(posedge clk) cyc <= cyc + 1;
  assign frame_start = (cyc % 10 == 9);

  task automatic checkOutput(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_pos_x"}, int'(pos_x), 0);
    checkOutput({tag, "_pos_y"}, int'(pos_y), 0);
    checkOutput({tag, "_sel_valid"}, int'(sel_valid), 0);
    checkOutput({tag, "_sel_x"}, int'(sel_x), 0);
    checkOutput({tag, "_sel_y"}, int'(sel_y), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    do @(negedge clk); while (cyc % 10 != p);
  endtask

  // btns = {up, down, left, right, sel}
  task automatic applyStimulus(input logic [4:0] btns, input int hold, input int settle);
    wait_phase(4);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = btns;
    tick(hold);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
    tick(settle);
  endtask

  // Monitor: every select strobe and every displayed-position change consumes one expectation.
  initial begin
    int prev;
    int now;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0;
      end else begin
        now = int'(pos_x) * 10 + int'(pos_y);
        if (sel_valid) begin
          if (sel_q.size() == 0) checkOutput("sel_unexpected", int'(sel_x) * 10 + int'(sel_y), -1);
          else checkOutput("sel_xy", int'(sel_x) * 10 + int'(sel_y), sel_q.pop_front());
        end
        if (now != prev) begin
          if (pos_q.size() == 0) checkOutput("pos_unexpected", now, -1);
          else checkOutput("pos_xy", now, pos_q.pop_front());
          checkOutput("pos_frame_phase", cyc % 10, 0);
        end
        prev = now;
      end
    end
  end

  initial begin
    #1;
    checkReset("por");
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // 3-cycle glitch on up must be rejected.
    wait_phase(4);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(30);

    // Clean up press from row 0 wraps to row 7.
    pos_q.push_back(7);
    applyStimulus(5'b10000, 10, 30);

    // Async reset while right is mid-debounce; still held at release, so it steps once.
    wait_phase(4);
    btn_right = 1'b1;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midrun");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pos_q.push_back(10);
    tick(10);
    btn_right = 1'b0;
    tick(30);

    // Hold right 60 cycles: steps at +0,+20,+28,+36,+44,+52 land on five frames.
    pos_q.push_back(20);
    pos_q.push_back(30);
    pos_q.push_back(40);
    pos_q.push_back(50);
    pos_q.push_back(60);
    applyStimulus(5'b00010, 60, 30);

    // Diagonal down+right, then left+right cancel with down.
    pos_q.push_back(71);
    applyStimulus(5'b01010, 10, 30);
    pos_q.push_back(72);
    applyStimulus(5'b01110, 10, 30);

    // Select held for 100 cycles yields a single strobe.
    sel_q.push_back(72);
    applyStimulus(5'b00001, 100, 30);

    // Wrap at both column edges.
    pos_q.push_back(2);
    applyStimulus(5'b00010, 10, 30);
    pos_q.push_back(72);
    applyStimulus(5'b00100, 10, 30);

    // Lock raised after a step is pending but before its frame: step is discarded.
    wait_phase(4);
    btn_right = 1'b1;
    tick(9);
    lock = 1'b1;
    tick(1);
    btn_right = 1'b0;
    tick(30);
    lock = 1'b0;
    tick(10);

    // Buttons pressed under lock and still held when it drops: nothing happens.
    lock = 1'b1;
    tick(2);
    btn_down = 1'b1;
    btn_sel = 1'b1;
    tick(40);
    lock = 1'b0;
    tick(40);
    btn_down = 1'b0;
    btn_sel = 1'b0;
    tick(30);

    // Fresh presses after unlock work again.
    pos_q.push_back(73);
    applyStimulus(5'b01000, 10, 30);
    sel_q.push_back(73);
    applyStimulus(5'b00001, 10, 30);

    tick(20);
    while (pos_q.size() != 0) checkOutput("pos_missing", -1, pos_q.pop_front());
    while (sel_q.size() != 0) checkOutput("sel_missing", -1, sel_q.pop_front());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
